// File: rtl/pwr_fault_pkg.sv
// Shared types and constants for the power-fault monitor slice.
package pwr_fault_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_LATCHED = 2'd1,
      ST_ACK     = 2'd2,
      ST_HOLD    = 2'd3
   } state_e;

   localparam logic [2:0]  SEL_IDLE   = 3'd7;
   localparam logic        FT_UNDER   = 1'b0;
   localparam logic        FT_OVER    = 1'b1;
   localparam int unsigned NUM_CH_DEF = 7;

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/pwr_fault_counters.sv
// Per-channel saturating fault counters with a registered read port.
module pwr_fault_counters
   import pwr_fault_pkg::*;
#(
   parameter int unsigned NUM_CH = NUM_CH_DEF,
   parameter int unsigned CNT_W  = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             inc_en,
   input  logic [2:0]       inc_idx,
   input  logic [2:0]       rd_sel,
   output logic [CNT_W-1:0] rd_data
);

   logic [CNT_W-1:0] cnt_q [NUM_CH];
   logic [CNT_W-1:0] cnt_d [NUM_CH];
   logic [CNT_W-1:0] rd_data_q;
   logic [CNT_W-1:0] rd_data_d;

   always_comb begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         cnt_d[i] = cnt_q[i];
         if (inc_en && (inc_idx == 3'(i)) && (cnt_q[i] != '1)) begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
      // Reads the pre-update array, so a same-cycle increment is not yet visible.
      rd_data_d = '0;
      if (32'(rd_sel) < NUM_CH) begin
         rd_data_d = cnt_q[rd_sel];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            cnt_q[i] <= '0;
         end
         rd_data_q <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/pwr_fault_monitor.sv
// Latches power-management faults, interrupts the host and handshakes ack/hold-off.
// Optional PWR_FAULT_AUTO_ACK_EN: leave LATCHED automatically after AUTO_ACK_CYCLES.
module pwr_fault_monitor
   import pwr_fault_pkg::*;
#(
   parameter int unsigned NUM_CH          = NUM_CH_DEF,
   parameter int unsigned CNT_W           = 8,
   parameter int unsigned ACK_CYCLES      = 4,
   parameter int unsigned HOLDOFF         = 50000,
   parameter int unsigned AUTO_ACK_CYCLES = 500000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             pwr_error,
   input  logic [2:0]       pwr_sel,
   output logic             pwr_ack,
   input  logic             host_clr,
   output logic             irq,
   output logic             fault_valid,
   output logic [2:0]       fault_ch,
   output logic             fault_type,
   input  logic [2:0]       cnt_rd_sel,
   output logic [CNT_W-1:0] cnt_rd_data,
   output logic [15:0]      fault_total,
   output logic [1:0]       state
);

   // One shared timer serves ACK, HOLD and the optional auto-ack window.
   localparam int unsigned TMR_W = $clog2(max3(ACK_CYCLES, HOLDOFF, AUTO_ACK_CYCLES) + 1);

   state_e           state_q, state_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic             fault_valid_q, fault_valid_d;
   logic [2:0]       fault_ch_q, fault_ch_d;
   logic             fault_type_q, fault_type_d;
   logic [15:0]      fault_total_q, fault_total_d;
   logic             cnt_inc;
   logic             leave_latched;

   always_comb begin
      state_d       = state_q;
      tmr_d         = tmr_q;
      fault_valid_d = fault_valid_q;
      fault_ch_d    = fault_ch_q;
      fault_type_d  = fault_type_q;
      fault_total_d = fault_total_q;
      cnt_inc       = 1'b0;
      leave_latched = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (pwr_error && (pwr_sel != SEL_IDLE)) begin
               state_d       = ST_LATCHED;
               tmr_d         = '0;
               fault_valid_d = 1'b1;
               fault_ch_d    = pwr_sel;
               fault_type_d  = pwr_sel[0] ? FT_OVER : FT_UNDER;
               cnt_inc       = 1'b1;
               if (fault_total_q != '1) begin
                  fault_total_d = fault_total_q + 16'd1;
               end
            end
         end
         ST_LATCHED: begin
`ifdef PWR_FAULT_AUTO_ACK_EN
            tmr_d         = tmr_q + TMR_W'(1);
            leave_latched = host_clr || (tmr_q == TMR_W'(AUTO_ACK_CYCLES - 1));
`else
            leave_latched = host_clr;
`endif
            if (leave_latched) begin
               state_d       = ST_ACK;
               tmr_d         = '0;
               fault_valid_d = 1'b0;
            end
         end
         ST_ACK: begin
            if (tmr_q == TMR_W'(ACK_CYCLES - 1)) begin
               state_d = ST_HOLD;
               tmr_d   = '0;
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
            end
         end
         ST_HOLD: begin
            if (tmr_q == TMR_W'(HOLDOFF - 1)) begin
               state_d = ST_IDLE;
               tmr_d   = '0;
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         tmr_q         <= '0;
         fault_valid_q <= 1'b0;
         fault_ch_q    <= '0;
         fault_type_q  <= FT_UNDER;
         fault_total_q <= '0;
      end else begin
         state_q       <= state_d;
         tmr_q         <= tmr_d;
         fault_valid_q <= fault_valid_d;
         fault_ch_q    <= fault_ch_d;
         fault_type_q  <= fault_type_d;
         fault_total_q <= fault_total_d;
      end
   end

   pwr_fault_counters #(
      .NUM_CH (NUM_CH),
      .CNT_W  (CNT_W)
   ) u_counters (
      .clk     (clk),
      .reset_n (reset_n),
      .inc_en  (cnt_inc),
      .inc_idx (pwr_sel),
      .rd_sel  (cnt_rd_sel),
      .rd_data (cnt_rd_data)
   );

   assign irq         = (state_q == ST_LATCHED);
   assign pwr_ack     = (state_q == ST_ACK);
   assign fault_valid = fault_valid_q;
   assign fault_ch    = fault_ch_q;
   assign fault_type  = fault_type_q;
   assign fault_total = fault_total_q;
   assign state       = state_q;

endmodule

// File: tb/tb_pwr_fault_monitor.sv
// Directed bench for pwr_fault_monitor with a timeline-based reference model.
module tb_pwr_fault_monitor;

   localparam int NCH  = 7;
   localparam int CW   = 2;
   localparam int A    = 4;
   localparam int H    = 20;
   localparam int AU   = 30;
   localparam int CMAX = (1 << CW) - 1;
`ifdef PWR_FAULT_AUTO_ACK_EN
   localparam bit AUTO_EN = 1'b1;
`else
   localparam bit AUTO_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          pwr_error = 1'b0;
   logic [2:0]    pwr_sel = 3'd0;
   logic          host_clr = 1'b0;
   logic [2:0]    cnt_rd_sel = 3'd0;
   logic          pwr_ack, irq, fault_valid, fault_type;
   logic [2:0]    fault_ch;
   logic [CW-1:0] cnt_rd_data;
   logic [15:0]   fault_total;
   logic [1:0]    state;

   pwr_fault_monitor #(
      .NUM_CH          (NCH),
      .CNT_W           (CW),
      .ACK_CYCLES      (A),
      .HOLDOFF         (H),
      .AUTO_ACK_CYCLES (AU)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .pwr_error   (pwr_error),
      .pwr_sel     (pwr_sel),
      .pwr_ack     (pwr_ack),
      .host_clr    (host_clr),
      .irq         (irq),
      .fault_valid (fault_valid),
      .fault_ch    (fault_ch),
      .fault_type  (fault_type),
      .cnt_rd_sel  (cnt_rd_sel),
      .cnt_rd_data (cnt_rd_data),
      .fault_total (fault_total),
      .state       (state)
   );

   always #10 clk = ~clk;

   int vectors = 0;
   int errors  = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   // Model: phases derived from the edge index of the last clear, not from a state register.
   int e          = 0;
   int clr_edge   = -1000000;
   int lat_edge   = 0;
   bit lat        = 1'b0;
   int m_cnt [NCH];
   int m_total    = 0;
   int m_rd       = 0;
   int m_ch       = 0;
   int m_type     = 0;

   function int phase_at(input int k);
      if (lat) return 1;
      if (k < clr_edge + A) return 2;
      if (k < clr_edge + A + H) return 3;
      return 0;
   endfunction

   always @(posedge clk or negedge reset_n) begin
      int p;
      int rs;
      if (!reset_n) begin
         e = 0; clr_edge = -1000000; lat = 1'b0; m_total = 0; m_rd = 0; m_ch = 0; m_type = 0;
         for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
      end else begin
         e  = e + 1;
         p  = phase_at(e - 1);
         rs = int'(cnt_rd_sel);
         m_rd = 0;
         if (rs < NCH) m_rd = m_cnt[rs];
         if (p == 0 && pwr_error && pwr_sel != 3'd7) begin
            lat = 1'b1; lat_edge = e; m_ch = int'(pwr_sel); m_type = int'(pwr_sel) % 2;
            if (m_cnt[m_ch] < CMAX) m_cnt[m_ch] = m_cnt[m_ch] + 1;
            if (m_total < 65535) m_total = m_total + 1;
         end else if (p == 1 && (host_clr || (AUTO_EN && (e - lat_edge >= AU)))) begin
            lat = 1'b0; clr_edge = e;
         end
      end
   end

   always @(negedge clk) begin
      if (reset_n) begin
         check("m_state", state, phase_at(e));
         check("m_irq", irq, lat);
         check("m_valid", fault_valid, lat);
         check("m_ack", pwr_ack, phase_at(e) == 2);
         check("m_ch", fault_ch, m_ch);
         check("m_type", fault_type, m_type);
         check("m_rd", cnt_rd_data, m_rd);
         check("m_total", fault_total, m_total);
      end
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic capture(input int ch);
      pwr_sel = 3'(ch); pwr_error = 1'b1;
      step();
      pwr_error = 1'b0;
   endtask

   task automatic clear();
      host_clr = 1'b1;
      step();
      host_clr = 1'b0;
   endtask

   task automatic wait_idle(input int budget, output int n);
      n = 0;
      while (state !== 2'd0 && n < budget) begin
         step();
         n++;
      end
      if (state !== 2'd0) check("wait_idle_timeout", state, 0);
   endtask

   initial begin
      int n;
      int k;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      check("rst_state", state, 0);
      check("rst_irq", irq, 0);
      check("rst_ack", pwr_ack, 0);
      check("rst_total", fault_total, 0);
      check("rst_rd", cnt_rd_data, 0);

      // Undervolt capture and clear
      capture(2);
      check("uv_ch", fault_ch, 2);
      check("uv_type", fault_type, 0);
      check("uv_irq", irq, 1);
      check("uv_total", fault_total, 1);
      cnt_rd_sel = 3'd2;
      step();
      check("uv_cnt2", cnt_rd_data, 1);
      clear();
      wait_idle(100, n);
      check("uv_idle_delay", n, A + H);

      // Overvolt, clear 10 cycles later, ack pulse width
      capture(5);
      check("ov_type", fault_type, 1);
      check("ov_ch", fault_ch, 5);
      step(9);
      clear();
      check("ov_irq_drop", irq, 0);
      k = 0;
      for (int i = 0; i < 10; i++) begin
         if (pwr_ack === 1'b1) k++;
         step();
      end
      check("ov_ack_len", k, 4);
      wait_idle(100, n);
      check("ov_idle_delay", n + 10, 24);

      // Hold-off masking, then recapture with error held high
      capture(4);
      clear();
      step(5);
      pwr_sel = 3'd1; pwr_error = 1'b1;
      step();
      pwr_error = 1'b0;
      check("ho_state", state, 3);
      check("ho_valid", fault_valid, 0);
      check("ho_total", fault_total, 3);
      pwr_sel = 3'd4; pwr_error = 1'b1;
      n = 0;
      while (fault_valid !== 1'b1 && n < 100) begin
         step();
         n++;
      end
      pwr_error = 1'b0;
      check("ho_recap_delay", n, 19);
      cnt_rd_sel = 3'd4;
      step();
      check("ho_cnt4", cnt_rd_data, 2);
      clear();
      wait_idle(100, n);

      // Simultaneous error and clear in LATCHED: clear wins
      capture(3);
      pwr_sel = 3'd6; pwr_error = 1'b1; host_clr = 1'b1;
      step();
      pwr_error = 1'b0; host_clr = 1'b0;
      check("sim_state", state, 2);
      check("sim_ch", fault_ch, 3);
      check("sim_total", fault_total, 5);
      wait_idle(100, n);

      // Saturation on ch 0, idle select, stray host_clr
      for (int i = 0; i < 5; i++) begin
         capture(0);
         clear();
         wait_idle(100, n);
      end
      cnt_rd_sel = 3'd0;
      step();
      check("sat_cnt0", cnt_rd_data, 3);
      check("sat_total", fault_total, 10);
      pwr_sel = 3'd7; pwr_error = 1'b1;
      step(3);
      pwr_error = 1'b0;
      check("idle_sel_state", state, 0);
      check("idle_sel_total", fault_total, 10);
      cnt_rd_sel = 3'd7;
      step();
      check("rd_sel7", cnt_rd_data, 0);
      host_clr = 1'b1;
      step();
      host_clr = 1'b0;
      check("stray_clr_state", state, 0);

      // Async reset mid-ack
      capture(1);
      clear();
      step();
      check("ar_pre_ack", pwr_ack, 1);
      #4 reset_n = 1'b0;
      #1;
      check("ar_ack", pwr_ack, 0);
      check("ar_state", state, 0);
      check("ar_total", fault_total, 0);
      step(2);
      reset_n = 1'b1;
      for (int ch = 0; ch < NCH; ch++) begin
         cnt_rd_sel = 3'(ch);
         step();
         check("ar_cnt", cnt_rd_data, 0);
      end

      // Auto-ack window
      capture(6);
      step(29);
      check("au_ack_early", pwr_ack, 0);
      check("au_state_early", state, 1);
      step();
      if (AUTO_EN) begin
         check("au_ack", pwr_ack, 1);
      end else begin
         check("au_still_latched", irq, 1);
         clear();
      end
      wait_idle(100, n);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
